// File: rtl/lv1_spill_sequencer.sv
// Per-spill L1 accept sequencer: arms on spill start, applies per-accept dead time,
// honours ADC busy, caps accepts per spill, and pulses spill_done at spill close.
// A bypass mode (user_ena=0) passes gated candidates straight through.
module lv1_spill_sequencer #(
    parameter int unsigned CNT_W  = 10,
    parameter int unsigned DT_W   = 8,
    parameter int unsigned VETO_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              user_ena,
    input  logic              spill_on,
    input  logic              early_lv1,
    input  logic              adc_busy,
    input  logic [CNT_W-1:0]  ntrig,
    input  logic [DT_W-1:0]   deadtime,
    output logic              ena_lv1,
    output logic              lv1_accept,
    output logic [CNT_W-1:0]  trig_cnt,
    output logic [VETO_W-1:0] veto_cnt,
    output logic              spill_done,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLive  = 3'd1,
        StDead  = 3'd2,
        StFull  = 3'd3,
        StDrain = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0]  TrigOne = CNT_W'(1);
    localparam logic [VETO_W-1:0] VetoOne = VETO_W'(1);
    localparam logic [DT_W-1:0]   DtOne   = DT_W'(1);

    state_e             state_q, state_d;
    logic               ena_q, ena_d;
    logic               acc_q, acc_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   trig_q, trig_d;
    logic [VETO_W-1:0]  veto_q, veto_d;
    logic [DT_W-1:0]    dcnt_q, dcnt_d;
    logic [CNT_W-1:0]   limit_q, limit_d;
    logic [DT_W-1:0]    dt_q, dt_d;
    logic [CNT_W-1:0]   trig_sat;
    logic [VETO_W-1:0]  veto_sat;

    // Saturating increments; counters never wrap in either mode.
    always_comb begin
        trig_sat = (&trig_q) ? trig_q : trig_q + TrigOne;
        veto_sat = (&veto_q) ? veto_q : veto_q + VetoOne;
    end

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d = state_q;
        ena_d   = 1'b0;
        acc_d   = 1'b0;
        done_d  = 1'b0;
        trig_d  = trig_q;
        veto_d  = veto_q;
        dcnt_d  = dcnt_q;
        limit_d = limit_q;
        dt_d    = dt_q;

        if (!user_ena) begin
            state_d = StIdle;
            dcnt_d  = '0;
            if (early_lv1 && spill_on) begin
                acc_d  = 1'b1;
                trig_d = trig_sat;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (spill_on) begin
                        state_d = StLive;
                        trig_d  = '0;
                        veto_d  = '0;
                        limit_d = ntrig;
                        dt_d    = deadtime;
                    end
                end
                StLive: begin
                    // Spill end wins over a coincident candidate.
                    if (!spill_on) begin
                        state_d = StDrain;
                    end else if (early_lv1) begin
                        if (!adc_busy) begin
                            acc_d  = 1'b1;
                            trig_d = trig_sat;
                            if ((limit_q != '0) && (trig_sat == limit_q)) begin
                                state_d = StFull;
                            end else if (dt_q != '0) begin
                                state_d = StDead;
                                dcnt_d  = dt_q;
                            end
                        end else begin
                            veto_d = veto_sat;
                        end
                    end
                end
                StDead: begin
                    if (!spill_on) begin
                        state_d = StDrain;
                    end else begin
                        if (early_lv1) veto_d = veto_sat;
                        // Busy at expiry parks the counter at 1 until the digitiser frees up.
                        if (dcnt_q <= DtOne) begin
                            if (!adc_busy) begin
                                state_d = StLive;
                                dcnt_d  = '0;
                            end else begin
                                dcnt_d = DtOne;
                            end
                        end else begin
                            dcnt_d = dcnt_q - DtOne;
                        end
                    end
                end
                StFull: begin
                    if (!spill_on) begin
                        state_d = StDrain;
                    end else if (early_lv1) begin
                        veto_d = veto_sat;
                    end
                end
                StDrain: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end

        // Outputs are derived from the state being entered so they register alongside it.
        ena_d  = user_ena ? (state_d == StLive) : 1'b1;
        done_d = user_ena && (state_d == StDrain);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ena_q   <= 1'b0;
            acc_q   <= 1'b0;
            done_q  <= 1'b0;
            trig_q  <= '0;
            veto_q  <= '0;
            dcnt_q  <= '0;
            limit_q <= '0;
            dt_q    <= '0;
        end else begin
            state_q <= state_d;
            ena_q   <= ena_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            trig_q  <= trig_d;
            veto_q  <= veto_d;
            dcnt_q  <= dcnt_d;
            limit_q <= limit_d;
            dt_q    <= dt_d;
        end
    end

    assign ena_lv1    = ena_q;
    assign lv1_accept = acc_q;
    assign spill_done = done_q;
    assign trig_cnt   = trig_q;
    assign veto_cnt   = veto_q;
    assign state      = state_q;

endmodule

// File: tb/tb_lv1_spill_sequencer.sv
// Directed bench for lv1_spill_sequencer: limit, dead time, busy, bypass,
// spill-end priority with parameter re-latch, and asynchronous reset.
module tb_lv1_spill_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        user_ena = 1'b0;
    logic        spill_on = 1'b0;
    logic        early_lv1 = 1'b0;
    logic        adc_busy = 1'b0;
    logic [9:0]  ntrig = '0;
    logic [7:0]  deadtime = '0;
    logic        ena_lv1;
    logic        lv1_accept;
    logic [9:0]  trig_cnt;
    logic [15:0] veto_cnt;
    logic        spill_done;
    logic [2:0]  state;

    int n_tests = 0;
    int n_fail  = 0;
    int acc_seen, done_seen, ena_low;

    lv1_spill_sequencer #(.CNT_W(10), .DT_W(8), .VETO_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .user_ena   (user_ena),
        .spill_on   (spill_on),
        .early_lv1  (early_lv1),
        .adc_busy   (adc_busy),
        .ntrig      (ntrig),
        .deadtime   (deadtime),
        .ena_lv1    (ena_lv1),
        .lv1_accept (lv1_accept),
        .trig_cnt   (trig_cnt),
        .veto_cnt   (veto_cnt),
        .spill_done (spill_done),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Advance one clock and tally observed pulses 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (lv1_accept) acc_seen++;
        if (spill_done) done_seen++;
        if (!ena_lv1) ena_low++;
    endtask

    task automatic clear_tally();
        acc_seen = 0;
        done_seen = 0;
        ena_low = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_tests++;
        if ({ena_lv1, lv1_accept, spill_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000", {ena_lv1, lv1_accept, spill_done});
        end
        n_tests++;
        if (trig_cnt !== 10'd0 || veto_cnt !== 16'd0 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got trig=%0d veto=%0d state=%0d want 0/0/0",
                     trig_cnt, veto_cnt, state);
        end
        apply_reset();
    endtask

    task automatic test_limit();
        user_ena = 1'b1; ntrig = 10'd3; deadtime = 8'd0; spill_on = 1'b1;
        cyc();
        n_tests++;
        if (state !== 3'd1 || ena_lv1 !== 1'b1) begin
            n_fail++;
            $display("FAIL limit_enter_live: got state=%0d ena=%b want 1/1", state, ena_lv1);
        end
        clear_tally();
        for (int i = 0; i < 5; i++) begin
            early_lv1 = 1'b1; cyc();
            early_lv1 = 1'b0; cyc();
        end
        n_tests++;
        if (acc_seen !== 3) begin
            n_fail++;
            $display("FAIL limit_accepts: got %0d want 3", acc_seen);
        end
        n_tests++;
        if (trig_cnt !== 10'd3 || veto_cnt !== 16'd2 || state !== 3'd3) begin
            n_fail++;
            $display("FAIL limit_full: got trig=%0d veto=%0d state=%0d want 3/2/3",
                     trig_cnt, veto_cnt, state);
        end
        clear_tally();
        spill_on = 1'b0;
        cyc();
        n_tests++;
        if (state !== 3'd4 || spill_done !== 1'b1) begin
            n_fail++;
            $display("FAIL limit_drain: got state=%0d done=%b want 4/1", state, spill_done);
        end
        cyc();
        n_tests++;
        if (done_seen !== 1 || state !== 3'd0 || trig_cnt !== 10'd3) begin
            n_fail++;
            $display("FAIL limit_close: got done=%0d state=%0d trig=%0d want 1/0/3",
                     done_seen, state, trig_cnt);
        end
    endtask

    task automatic test_deadtime();
        logic [12:0] mask;
        mask = '0;
        ntrig = 10'd0; deadtime = 8'd4; spill_on = 1'b1;
        cyc();
        n_tests++;
        if (trig_cnt !== 10'd0 || veto_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL dt_clear: got trig=%0d veto=%0d want 0/0", trig_cnt, veto_cnt);
        end
        clear_tally();
        early_lv1 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (lv1_accept) mask[i] = 1'b1;
        end
        early_lv1 = 1'b0;
        n_tests++;
        if (mask !== 13'h0842) begin
            n_fail++;
            $display("FAIL dt_accept_slots: got %h want 0842", mask);
        end
        n_tests++;
        if (trig_cnt !== 10'd3 || veto_cnt !== 16'd9) begin
            n_fail++;
            $display("FAIL dt_counts: got trig=%0d veto=%0d want 3/9", trig_cnt, veto_cnt);
        end
        n_tests++;
        if (ena_low !== 10) begin
            n_fail++;
            $display("FAIL dt_ena_low: got %0d want 10", ena_low);
        end
        spill_on = 1'b0;
        cyc(); cyc();
    endtask

    task automatic test_busy();
        ntrig = 10'd0; deadtime = 8'd2; spill_on = 1'b1;
        cyc();
        clear_tally();
        adc_busy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            early_lv1 = 1'b1; cyc();
            early_lv1 = 1'b0; cyc();
        end
        n_tests++;
        if (acc_seen !== 0 || veto_cnt !== 16'd2 || state !== 3'd1) begin
            n_fail++;
            $display("FAIL busy_veto: got acc=%0d veto=%0d state=%0d want 0/2/1",
                     acc_seen, veto_cnt, state);
        end
        adc_busy = 1'b0; early_lv1 = 1'b1;
        cyc();
        early_lv1 = 1'b0; adc_busy = 1'b1;
        n_tests++;
        if (state !== 3'd2 || lv1_accept !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_accept: got state=%0d acc=%b want 2/1", state, lv1_accept);
        end
        for (int i = 0; i < 5; i++) cyc();
        n_tests++;
        if (state !== 3'd2 || ena_lv1 !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_hold_dead: got state=%0d ena=%b want 2/0", state, ena_lv1);
        end
        adc_busy = 1'b0;
        cyc();
        n_tests++;
        if (state !== 3'd1 || ena_lv1 !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_release: got state=%0d ena=%b want 1/1", state, ena_lv1);
        end
        spill_on = 1'b0;
        cyc(); cyc();
    endtask

    task automatic test_bypass();
        apply_reset();
        user_ena = 1'b0; spill_on = 1'b1; ntrig = 10'd2; deadtime = 8'd3;
        cyc();
        clear_tally();
        for (int i = 0; i < 7; i++) begin
            early_lv1 = 1'b1; cyc();
            early_lv1 = 1'b0; cyc();
        end
        n_tests++;
        if (acc_seen !== 7 || trig_cnt !== 10'd7) begin
            n_fail++;
            $display("FAIL bypass_accepts: got acc=%0d trig=%0d want 7/7", acc_seen, trig_cnt);
        end
        n_tests++;
        if (ena_low !== 0 || done_seen !== 0 || veto_cnt !== 16'd0 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL bypass_misc: got ena_low=%0d done=%0d veto=%0d state=%0d want 0/0/0/0",
                     ena_low, done_seen, veto_cnt, state);
        end
    endtask

    task automatic test_priority_relatch();
        user_ena = 1'b1; ntrig = 10'd5; deadtime = 8'd0; spill_on = 1'b1;
        cyc();
        ntrig = 10'd1;
        early_lv1 = 1'b1; cyc();
        early_lv1 = 1'b0; cyc();
        n_tests++;
        if (state !== 3'd1 || trig_cnt !== 10'd1) begin
            n_fail++;
            $display("FAIL relatch_hold: got state=%0d trig=%0d want 1/1", state, trig_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            early_lv1 = 1'b1; cyc();
            early_lv1 = 1'b0; cyc();
        end
        n_tests++;
        if (state !== 3'd3 || trig_cnt !== 10'd5) begin
            n_fail++;
            $display("FAIL relatch_full5: got state=%0d trig=%0d want 3/5", state, trig_cnt);
        end
        spill_on = 1'b0; cyc(); cyc();
        spill_on = 1'b1; cyc();
        early_lv1 = 1'b1; spill_on = 1'b0;
        cyc();
        early_lv1 = 1'b0;
        n_tests++;
        if (state !== 3'd4 || lv1_accept !== 1'b0 || spill_done !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_drain: got state=%0d acc=%b done=%b want 4/0/1",
                     state, lv1_accept, spill_done);
        end
        n_tests++;
        if (trig_cnt !== 10'd0 || veto_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL prio_counts: got trig=%0d veto=%0d want 0/0", trig_cnt, veto_cnt);
        end
        cyc();
        spill_on = 1'b1; cyc();
        early_lv1 = 1'b1; cyc();
        early_lv1 = 1'b0;
        n_tests++;
        if (state !== 3'd3 || trig_cnt !== 10'd1) begin
            n_fail++;
            $display("FAIL relatch_new_limit: got state=%0d trig=%0d want 3/1", state, trig_cnt);
        end
        spill_on = 1'b0; cyc(); cyc();
    endtask

    task automatic test_async_reset();
        ntrig = 10'd0; deadtime = 8'd2; spill_on = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            early_lv1 = 1'b1; cyc();
            early_lv1 = 1'b0;
            if (i < 3) begin
                cyc(); cyc();
            end
        end
        n_tests++;
        if (state !== 3'd2 || trig_cnt !== 10'd4 || lv1_accept !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_setup: got state=%0d trig=%0d acc=%b want 2/4/1",
                     state, trig_cnt, lv1_accept);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (ena_lv1 !== 1'b0 || trig_cnt !== 10'd0 || state !== 3'd0 || lv1_accept !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_immediate: got ena=%b trig=%0d state=%0d acc=%b want 0/0/0/0",
                     ena_lv1, trig_cnt, state, lv1_accept);
        end
        spill_on = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        clear_tally();
        test_reset();
        test_limit();
        test_deadtime();
        test_busy();
        test_bypass();
        test_priority_relatch();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lv1_spill_sequencer.md
Name: lv1_spill_sequencer

Overview:
- Per-spill controller for the L1 trigger path in the top CDT.
- Decides when early L1 candidates become accepted L1s. It arms at spill start and enforces a per-accept dead time, honours downstream ADC busy, and caps accepts per spill at a programmable limit.
- Closes the spill with a done pulse and exposes counters for monitoring.
- Bypass mode passes triggers through, unrestricted, whenever user_ena is low.

Parameters:
CNT_W, 10, width of trigger limit and accept counter
DT_W, 8, width of dead-time setting/counter
VETO_W, 16, width of vetoed-trigger counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
user_ena  input  1  1 = restricted/sequenced mode, 0 = bypass
spill_on  input  1  spill gate, synchronous to clk
early_lv1  input  1  early L1 candidate, 1-cycle pulse per candidate
adc_busy  input  1  downstream digitiser busy
ntrig  input  CNT_W  max accepts per spill; 0 = unlimited
deadtime  input  DT_W  cycles of forced dead time after each accept; 0 = none
ena_lv1  output  1  L1 enable, registered
lv1_accept  output  1  one-cycle pulse per accepted trigger, registered
trig_cnt  output  CNT_W  accepts in current spill
veto_cnt  output  VETO_W  candidates rejected in current spill
spill_done  output  1  one-cycle pulse at spill close
state  output  3  current FSM state code

Behaviour:
- Reset (async, rst=1): state=IDLE, ena_lv1=0, lv1_accept=0, trig_cnt=0, veto_cnt=0, spill_done=0, dead-time counter=0.
- State codes: IDLE=0, LIVE=1, DEAD=2, FULL=3, DRAIN=4; codes 5-7 are illegal and return to IDLE on the next clock.
- Bypass (user_ena=0, any state):
  - Next clock forces state=IDLE and ena_lv1=1.
  - lv1_accept = registered (early_lv1 & spill_on).
  - trig_cnt increments on each such accept, saturating at all-ones. Limit, dead time and adc_busy are ignored.
  - veto_cnt holds its value.
  - spill_done is never asserted in bypass.
- Restricted mode (user_ena=1). All transitions take effect on the next clock edge; outputs are registered.
- IDLE:
  - ena_lv1=0.
  - spill_on=1 -> LIVE. On entry, trig_cnt=0 and veto_cnt=0, and ntrig and deadtime are latched into internal registers.
  - Later changes to ntrig or deadtime have no effect until the next spill.
- LIVE:
  - ena_lv1=1.
  - early_lv1=1 & adc_busy=0 -> accept:
    - lv1_accept=1 on the next cycle (latency 1) and trig_cnt+1.
    - If the latched limit ≠0 and trig_cnt+1 == limit -> FULL.
    - Otherwise, if the latched deadtime ≠0 -> DEAD, with the dead-time counter loaded with deadtime.
    - Otherwise stay in LIVE.
  - early_lv1=1 & adc_busy=1 -> reject: veto_cnt+1, saturating at all-ones.
  - spill_on=0 -> DRAIN. If early_lv1 occurs in the same cycle that spill_on=0, it is neither accepted nor vetoed; spill end takes priority.
- DEAD:
  - ena_lv1=0.
  - The dead-time counter decrements each cycle.
  - Any early_lv1 increments veto_cnt.
  - When the counter is 1 and adc_busy=0 -> LIVE. If adc_busy=1, the counter holds at 1 and the state stays DEAD.
  - Net effect: the earliest re-accept is deadtime+1 cycles after the accepting candidate.
  - spill_on=0 -> DRAIN, with priority over the return to LIVE.
- FULL:
  - ena_lv1=0.
  - early_lv1 increments veto_cnt.
  - spill_on=0 -> DRAIN.
- DRAIN:
  - ena_lv1=0 and spill_done=1 for exactly one cycle, then IDLE.
  - trig_cnt and veto_cnt hold until the next LIVE entry.
- user_ena 1->0 mid-spill: immediate bypass; no spill_done. Returning 1 with spill_on still high re-enters LIVE via IDLE and clears the counters.
- Counter width rule: the ntrig compare is an equality on CNT_W bits. With limit=all-ones, FULL is reached at trig_cnt=all-ones, so the counter never wraps in restricted mode.
- rst asserted mid-operation: all outputs go immediately to their reset values. This includes dropping a lv1_accept pulse in flight.

Test Plan:
- Limit: user_ena=1, ntrig=3, deadtime=0, spill_on=1, 5 early_lv1 pulses 2 cycles apart -> exactly 3 lv1_accept pulses, trig_cnt=3, veto_cnt=2, state=FULL. spill_on=0 -> one spill_done, state IDLE.
- Dead time: ntrig=0, deadtime=4, early_lv1 every cycle for 12 cycles -> accepts on candidates 1, 6 and 11 (5-cycle spacing), trig_cnt=3, veto_cnt=9, ena_lv1 low during DEAD.
- Busy: adc_busy=1 in LIVE with 2 candidates -> no accepts, veto_cnt=2. Busy held through dead-time expiry -> DEAD persists until adc_busy falls, then LIVE the next cycle.
- Bypass: user_ena=0, spill_on=1, 7 candidates, ntrig=2 -> 7 lv1_accept pulses, ena_lv1=1 throughout, trig_cnt=7, no spill_done.
- Spill-end priority and re-latch: early_lv1 in the same cycle spill_on falls -> no accept, no veto, DRAIN. Change ntrig mid-spill from 5 to 1 -> the limit stays 5 until the next spill.
- Async reset: assert rst in DEAD with trig_cnt=4 -> without waiting for a clock edge, ena_lv1=0, trig_cnt=0, state=IDLE, lv1_accept=0.
